// File: rtl/acc_alu_seq_pkg.sv
// Shared types for the accumulator ALU: extended op codes, control states
// and the core bus source select used by the surrounding datapath.
package acc_alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_CLR  = 4'h0,
    OP_PASS = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_MUL  = 4'h4,
    OP_INC  = 4'h5,
    OP_DEC  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_IDLE = 4'hF
  } alu_op_ext_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  typedef enum logic [1:0] {
    BUS_SEL_MEM = 2'd0,
    BUS_SEL_PC  = 2'd1,
    BUS_SEL_IR  = 2'd2,
    BUS_SEL_AC  = 2'd3
  } bus_in_sel_t;

endpackage

// File: rtl/acc_alu_seq_if.sv
// Op request / result bundle between the control unit (master) and the
// accumulator ALU (slave).
interface acc_alu_seq_if
  import acc_alu_seq_pkg::*;
#(
  parameter int WIDTH = 12
);
  logic                             op_valid;
  logic                             op_ready;
  logic [$bits(alu_op_ext_t)-1:0]   op;
  logic [WIDTH-1:0]                 bus_in;
  logic                             flush;
  logic [WIDTH-1:0]                 ac;
  logic                             done;
  logic                             z_flag;
  logic                             c_flag;
  logic                             v_flag;

  modport master (
    output op_valid, op, bus_in, flush,
    input  op_ready, ac, done, z_flag, c_flag, v_flag
  );

  modport slave (
    input  op_valid, op, bus_in, flush,
    output op_ready, ac, done, z_flag, c_flag, v_flag
  );
endinterface

// File: rtl/acc_alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks
// per product. result_o/done_o show the product completing on this edge.
module seq_mul_shift_add
  import acc_alu_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 busy_o,
  output logic                 done_o
);

  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   prod_d;

  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign result_o = prod_d;
  assign busy_o   = busy_q;
  assign done_o   = busy_q && !flush_i && (cnt_q == CNT_W'(1));

  // A start only arrives while idle, so it never collides with an active flush.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(WIDTH);
      mcand_q  <= {{WIDTH{1'b0}}, multiplicand_i};
      mplier_q <= multiplier_i;
      prod_q   <= '0;
    end else if (busy_q) begin
      if (flush_i) begin
        busy_q <= 1'b0;
      end else begin
        prod_q   <= prod_d;
        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU: single-cycle ops commit on the accepting edge, MUL runs
// on the iterative multiplier and commits WIDTH edges later.
module acc_alu_seq
  import acc_alu_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic          clk,
  input  logic          rstN,
  acc_alu_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  alu_state_t           state_q;
  logic [WIDTH-1:0]     ac_q;
  logic                 done_q;
  logic                 z_q;
  logic                 c_q;
  logic                 v_q;

  logic [WIDTH-1:0]     ac_d;
  logic                 c_d;
  logic                 writes_ac;
  logic [WIDTH:0]       wide;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_result;

  assign bus.op_ready = (state_q == ST_IDLE) && !mul_busy;
  assign bus.ac       = ac_q;
  assign bus.done     = done_q;
  assign bus.z_flag   = z_q;
  assign bus.c_flag   = c_q;
  assign bus.v_flag   = v_q;

  assign accept    = bus.op_valid && bus.op_ready;
  assign mul_start = accept && (bus.op == OP_MUL);

  seq_mul_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk            (clk),
    .rstN           (rstN),
    .start_i        (mul_start),
    .flush_i        (bus.flush),
    .multiplicand_i (ac_q),
    .multiplier_i   (bus.bus_in),
    .result_o       (mul_result),
    .busy_o         (mul_busy),
    .done_o         (mul_done)
  );

  // Single-cycle results; the extra top bit of 'wide' is the carry/borrow.
  always_comb begin
    ac_d      = ac_q;
    c_d       = c_q;
    writes_ac = 1'b0;
    wide      = '0;
    case (bus.op)
      OP_CLR: begin
        ac_d      = '0;
        writes_ac = 1'b1;
      end
      OP_PASS: begin
        ac_d      = bus.bus_in;
        writes_ac = 1'b1;
      end
      OP_ADD: begin
        wide      = {1'b0, ac_q} + {1'b0, bus.bus_in};
        ac_d      = wide[WIDTH-1:0];
        c_d       = wide[WIDTH];
        writes_ac = 1'b1;
      end
      OP_SUB: begin
        wide      = {1'b0, ac_q} - {1'b0, bus.bus_in};
        ac_d      = wide[WIDTH-1:0];
        c_d       = wide[WIDTH];
        writes_ac = 1'b1;
      end
      OP_INC: begin
        wide      = {1'b0, ac_q} + (WIDTH+1)'(1);
        ac_d      = wide[WIDTH-1:0];
        c_d       = wide[WIDTH];
        writes_ac = 1'b1;
      end
      OP_DEC: begin
        wide      = {1'b0, ac_q} - (WIDTH+1)'(1);
        ac_d      = wide[WIDTH-1:0];
        c_d       = wide[WIDTH];
        writes_ac = 1'b1;
      end
      OP_SHL: begin
        ac_d      = {ac_q[WIDTH-2:0], 1'b0};
        c_d       = ac_q[WIDTH-1];
        writes_ac = 1'b1;
      end
      OP_SHR: begin
        ac_d      = {1'b0, ac_q[WIDTH-1:1]};
        c_d       = ac_q[0];
        writes_ac = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Undefined and IDLE codes still pulse done so the control unit never stalls.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      ac_q    <= '0;
      done_q  <= 1'b0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              state_q <= ST_MUL;
            end else begin
              ac_q   <= ac_d;
              c_q    <= c_d;
              done_q <= 1'b1;
              if (writes_ac) begin
                z_q <= (ac_d == '0);
              end
            end
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
          end else if (mul_done) begin
            ac_q    <= mul_result[WIDTH-1:0];
            v_q     <= |mul_result[2*WIDTH-1:WIDTH];
            z_q     <= (mul_result[WIDTH-1:0] == '0);
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq: directed vector table, hand-written
// multi-cycle sequences, then random ops against an arithmetic model.
module tb_acc_alu_seq;
  import acc_alu_seq_pkg::*;

  localparam int W   = 12;
  localparam int MOD = 1 << W;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] expAc;
    logic         expC;
    logic         expZ;
    logic         expV;
    int           expLat;
  } vec_t;

  logic clk;
  logic rstN;
  int   nCompared;
  int   nMismatched;

  int   mAc;
  int   mC;
  int   mV;
  int   mZ;

  acc_alu_seq_if #(.WIDTH(W)) bus ();

  acc_alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one op, waits for acceptance and for done; returns at the done negedge.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] d,
                               output int lat, output int rdyLow);
    int guard;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.bus_in   = d;
    guard = 0;
    while (!bus.op_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.op_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept_timeout: got op_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    lat    = 1;
    rdyLow = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.op_ready) rdyLow++;
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL done_timeout: got done=0, expected 1 within 40 cycles");
    end
  endtask

  function automatic void modelReset();
    mAc = 0; mC = 0; mV = 0; mZ = 1;
  endfunction

  function automatic void modelStep(input int o, input int d);
    int p;
    case (o)
      0: mAc = 0;
      1: mAc = d;
      2: begin p = mAc + d; mC = (p >= MOD) ? 1 : 0; mAc = p % MOD; end
      3: begin mC = (mAc < d) ? 1 : 0; mAc = (mAc - d + MOD) % MOD; end
      4: begin p = mAc * d; mV = (p >= MOD) ? 1 : 0; mAc = p % MOD; end
      5: begin p = mAc + 1; mC = (p >= MOD) ? 1 : 0; mAc = p % MOD; end
      6: begin mC = (mAc == 0) ? 1 : 0; mAc = (mAc + MOD - 1) % MOD; end
      7: begin mC = (mAc >= MOD / 2) ? 1 : 0; mAc = (mAc * 2) % MOD; end
      8: begin mC = mAc % 2; mAc = mAc / 2; end
      default: ;
    endcase
    if (o <= 8) mZ = (mAc == 0) ? 1 : 0;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[15];
    logic [W-1:0] incAc[4];
    logic         incC[4];
    logic         incZ[4];
    int           lat;
    int           rl;
    int           doneSeen;
    logic [3:0]   ro;
    logic [W-1:0] rd;

    nCompared   = 0;
    nMismatched = 0;

    vecs[0]  = '{OP_PASS, 12'h0FF, 12'h0FF, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{OP_ADD,  12'hF01, 12'h000, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_PASS, 12'h005, 12'h005, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{OP_MUL,  12'h007, 12'h023, 1'b1, 1'b0, 1'b0, 13};
    vecs[4]  = '{OP_PASS, 12'h010, 12'h010, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{OP_MUL,  12'h100, 12'h000, 1'b1, 1'b1, 1'b1, 13};
    vecs[6]  = '{OP_DEC,  12'h000, 12'hFFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[7]  = '{OP_SHR,  12'h000, 12'h7FF, 1'b1, 1'b0, 1'b1, 1};
    vecs[8]  = '{OP_SHL,  12'h000, 12'hFFE, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'hB,    12'h123, 12'hFFE, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{OP_IDLE, 12'h456, 12'hFFE, 1'b0, 1'b0, 1'b1, 1};
    vecs[11] = '{OP_SUB,  12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[12] = '{OP_CLR,  12'h777, 12'h000, 1'b1, 1'b1, 1'b1, 1};
    vecs[13] = '{OP_PASS, 12'h003, 12'h003, 1'b1, 1'b0, 1'b1, 1};
    vecs[14] = '{OP_MUL,  12'h004, 12'h00C, 1'b1, 1'b0, 1'b0, 13};

    incAc[0] = 12'hFFF; incC[0] = 1'b0; incZ[0] = 1'b0;
    incAc[1] = 12'h000; incC[1] = 1'b1; incZ[1] = 1'b1;
    incAc[2] = 12'h001; incC[2] = 1'b0; incZ[2] = 1'b0;
    incAc[3] = 12'h002; incC[3] = 1'b0; incZ[3] = 1'b0;

    rstN         = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 4'h0;
    bus.bus_in   = '0;
    bus.flush    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ac",   32'(bus.ac),     32'h0);
    checkOutput("reset_z",    32'(bus.z_flag), 32'h1);
    checkOutput("reset_c",    32'(bus.c_flag), 32'h0);
    checkOutput("reset_v",    32'(bus.v_flag), 32'h0);
    checkOutput("reset_done", 32'(bus.done),   32'h0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(bus.op_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].din, lat, rl);
      checkOutput($sformatf("vec%0d_ac", i),  32'(bus.ac),     32'(vecs[i].expAc));
      checkOutput($sformatf("vec%0d_c", i),   32'(bus.c_flag), 32'(vecs[i].expC));
      checkOutput($sformatf("vec%0d_z", i),   32'(bus.z_flag), 32'(vecs[i].expZ));
      checkOutput($sformatf("vec%0d_v", i),   32'(bus.v_flag), 32'(vecs[i].expV));
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat),        32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_rdylow", i), 32'(rl),      32'(vecs[i].expLat - 1));
    end
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(bus.done), 32'h0);

    // Flush at cycle 5 of a MUL, with an INC held pending through the busy period.
    applyStimulus(OP_PASS, 12'h003, lat, rl);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.bus_in   = 12'h009;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.op     = OP_INC;
        bus.bus_in = '0;
      end
      checkOutput($sformatf("flush_busy%0d_ready", i), 32'(bus.op_ready), 32'h0);
      checkOutput($sformatf("flush_busy%0d_done", i),  32'(bus.done),     32'h0);
      if (i == 5) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_no_done", 32'(bus.done),     32'h0);
    checkOutput("flush_ac_kept", 32'(bus.ac),       32'h3);
    checkOutput("flush_ready",   32'(bus.op_ready), 32'h1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    checkOutput("held_inc_done", 32'(bus.done), 32'h1);
    checkOutput("held_inc_ac",   32'(bus.ac),   32'h4);
    @(negedge clk);
    checkOutput("held_inc_once", 32'(bus.ac), 32'h4);

    // Flush while idle must not disturb an op accepted on the same edge.
    bus.flush    = 1'b1;
    bus.op_valid = 1'b1;
    bus.op       = OP_PASS;
    bus.bus_in   = 12'h123;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    checkOutput("idle_flush_done", 32'(bus.done), 32'h1);
    checkOutput("idle_flush_ac",   32'(bus.ac),   32'h123);

    // Async reset in the middle of a multiply.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.bus_in   = 12'h005;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midmul_rst_ac",   32'(bus.ac),     32'h0);
    checkOutput("midmul_rst_z",    32'(bus.z_flag), 32'h1);
    checkOutput("midmul_rst_done", 32'(bus.done),   32'h0);
    @(negedge clk);
    rstN = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("midmul_no_late_done", 32'(doneSeen),     32'h0);
    checkOutput("midmul_ready",        32'(bus.op_ready), 32'h1);
    applyStimulus(4'hB, 12'hABC, lat, rl);
    checkOutput("undef_lat", 32'(lat),          32'h1);
    checkOutput("undef_ac",  32'(bus.ac),       32'h0);
    checkOutput("undef_z",   32'(bus.z_flag),   32'h1);
    checkOutput("undef_c",   32'(bus.c_flag),   32'h0);

    // Four INCs on consecutive edges.
    applyStimulus(OP_PASS, 12'hFFE, lat, rl);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_INC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("inc%0d_done", i), 32'(bus.done),   32'h1);
      checkOutput($sformatf("inc%0d_ac", i),   32'(bus.ac),     32'(incAc[i]));
      checkOutput($sformatf("inc%0d_c", i),    32'(bus.c_flag), 32'(incC[i]));
      checkOutput($sformatf("inc%0d_z", i),    32'(bus.z_flag), 32'(incZ[i]));
    end
    bus.op_valid = 1'b0;
    @(negedge clk);
    checkOutput("inc_done_drop", 32'(bus.done), 32'h0);
    checkOutput("inc_final_ac",  32'(bus.ac),   32'h2);

    // Random ops against the arithmetic model, from a fresh reset.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) ro = 4'($urandom_range(0, 15));
      else                           ro = 4'($urandom_range(0, 8));
      rd = W'($urandom);
      if ($urandom_range(0, 4) == 0) rd = W'($urandom_range(0, 3));
      applyStimulus(ro, rd, lat, rl);
      modelStep(int'(ro), int'(rd));
      checkOutput($sformatf("rnd%0d_op%0h_ac", i, ro), 32'(bus.ac),     32'(mAc));
      checkOutput($sformatf("rnd%0d_op%0h_c", i, ro),  32'(bus.c_flag), 32'(mC));
      checkOutput($sformatf("rnd%0d_op%0h_z", i, ro),  32'(bus.z_flag), 32'(mZ));
      checkOutput($sformatf("rnd%0d_op%0h_v", i, ro),  32'(bus.v_flag), 32'(mV));
      checkOutput($sformatf("rnd%0d_op%0h_lat", i, ro), 32'(lat), (ro == 4'h4) ? 32'(W + 1) : 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised accumulator ALU: AC <= f(AC, bus_in) per operation code; next generation of the processor-core ALU.
- Adds width generalisation, a valid/ready handshake, an iterative shift-add multiplier, new ops (DEC, SHL, SHR) and Z/C/V flags.
- Sits between the core bus mux and the control unit; the control unit issues ops and waits on done.

Parameters:
- WIDTH, 12, data/accumulator width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), multiplier iteration counter width (derived; do not override).

Ports:
- clk  input  1  core clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- op_valid  input  1  op request valid.
- op_ready  output  1  block can accept an op this cycle.
- op  input  4  alu_op_ext_t operation code.
- bus_in  input  WIDTH  operand from core bus.
- flush  input  1  synchronous abort of an in-flight multiply.
- ac  output  WIDTH  accumulator value (registered).
- done  output  1  one-cycle pulse: op result and flags committed.
- z_flag  output  1  ac == 0 after last committed op.
- c_flag  output  1  carry/borrow out of last ADD/SUB/INC/DEC/SHL/SHR.
- v_flag  output  1  MUL product exceeded WIDTH bits.

Behaviour:
- Reset (rstN=0, async): ac=0, done=0, z_flag=1, c_flag=0, v_flag=0, state=IDLE, op_ready=1 once rstN released.
- Handshake: accept when op_valid && op_ready at a rising edge; op and bus_in are sampled only at that edge.
- States: IDLE, MUL.
- IDLE: op_ready=1.
  - Non-MUL op accepted at edge k: ac, flags and done=1 update at edge k; state stays IDLE.
  - Back-to-back ops accepted on consecutive cycles.
- Op results (all mod 2^WIDTH):
  - CLR: 0. PASS: bus_in. ADD: ac+bus_in, c=carry. SUB: ac-bus_in, c=borrow (ac<bus_in).
  - INC: ac+1, c=carry. DEC: ac-1, c=borrow (ac==0).
  - SHL: ac<<1, c=old msb. SHR: ac>>1 logical, c=old lsb.
  - CLR/PASS leave c and v unchanged. Arithmetic/shift ops leave v unchanged.
  - IDLE code or undefined codes: ac and flags unchanged; done still pulses (acknowledge).
- MUL accepted at edge k:
  - Latch multiplicand=ac and multiplier=bus_in. Clear 2*WIDTH product. counter=WIDTH. state=MUL. op_ready=0.
  - Each edge in MUL: if multiplier lsb, add shifted multiplicand to product; shift multiplier right; counter--.
  - At the edge where counter goes 1->0: ac=product[WIDTH-1:0], v=|product[2W-1:W], z updated, c unchanged, done=1, state=IDLE.
  - done is high in cycle k+WIDTH+1; op_ready returns high that same cycle.
- z_flag is updated on every committed op that writes ac.
- flush: in MUL, next edge -> IDLE; ac and flags unchanged; no done. In IDLE, flush has no effect; an op accepted in the same cycle proceeds normally.
- done is a single-cycle pulse; it deasserts next edge unless another op commits.
- Async reset mid-MUL: immediate return to reset values; partial product discarded.
- op_valid while op_ready=0: ignored; the requester must hold op_valid until accepted.

Decomposition:
- Shared package: extended alu_op_ext_t (4-bit). CLR=0, PASS=1, ADD=2, SUB=3, MUL=4, INC=5, DEC=6, SHL=7, SHR=8, IDLE=4'hF (no x-valued members).
- Shared package: state typedef alu_state_t {IDLE, MUL}.
- Shared package: existing bus_in_sel_t is kept unchanged.
- One sub-module: seq_mul_shift_add, the iterative multiplier datapath (start, operands, flush -> product, busy, done). The top handles the handshake, single-cycle ops and flags.

Test Plan (WIDTH=12):
- Reset then PASS 12'h0FF -> done next cycle, ac=0x0FF, z=0. Then ADD 12'hF01 -> ac=0x000, c=1, z=1.
- ac=5, MUL bus_in=7 -> op_ready=0 for 12 cycles; done in cycle k+13; ac=35, v=0. Then MUL 12'h100 with ac=0x010 -> ac=0, v=1, z=1.
- ac=0: DEC -> ac=0xFFF, c=1. Then SHR -> ac=0x7FF, c=1. Then SHL -> ac=0xFFE, c=0.
- MUL started with ac=3; flush asserted at cycle 5 of MUL -> no done, ac=3, op_ready=1 next cycle. A new op during busy with op_valid held is accepted only after op_ready rises.
- rstN pulsed low mid-MUL -> ac=0, z=1, done=0 immediately. Undefined op 4'hB -> done pulses, ac and flags unchanged.
- Back-to-back INC x4 on consecutive cycles from ac=0xFFE -> ac sequence 0xFFF, 0x000 (c=1, z=1), 0x001, 0x002; done high all 4 cycles.
